// File: rtl/mure_uop_sequencer_if.sv
// Bundle between the trace connector FIFOs, the uop sequencer and the trace encoder.
// The master side is the sequencer; the slave side is the FIFO/encoder environment.
interface mure_uop_sequencer_if #(
    parameter int XLEN          = 32,
    parameter int CAUSE_LEN     = 5,
    parameter int PRIV_LEN      = 2,
    parameter int ITYPE_LEN     = 3,
    parameter int IRETIRE_LEN   = 3,
    parameter int ILASTSIZE_LEN = 1
);
    typedef struct packed {
        logic [ITYPE_LEN-1:0]     itype;
        logic [XLEN-1:0]          iaddr;
        logic [IRETIRE_LEN-1:0]   iretire;
        logic [ILASTSIZE_LEN-1:0] ilastsize;
    } uop_entry_s;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } common_entry_s;

    logic                     flush_i;
    logic                     uop_empty_i;
    uop_entry_s               uop_entry_i;
    logic                     uop_pop_o;
    logic                     common_empty_i;
    common_entry_s            common_entry_i;
    logic                     common_pop_o;
    logic                     valid_o;
    logic                     ready_i;
    logic [ITYPE_LEN-1:0]     itype_o;
    logic [XLEN-1:0]          iaddr_o;
    logic [IRETIRE_LEN-1:0]   iretire_o;
    logic [ILASTSIZE_LEN-1:0] ilastsize_o;
    logic [CAUSE_LEN-1:0]     cause_o;
    logic [XLEN-1:0]          tval_o;
    logic [PRIV_LEN-1:0]      priv_o;
    logic                     err_o;
    logic [15:0]              pkt_cnt_o;

    modport master (
        input  flush_i, uop_empty_i, uop_entry_i, common_empty_i, common_entry_i, ready_i,
        output uop_pop_o, common_pop_o, valid_o, itype_o, iaddr_o, iretire_o, ilastsize_o,
               cause_o, tval_o, priv_o, err_o, pkt_cnt_o
    );

    modport slave (
        output flush_i, uop_empty_i, uop_entry_i, common_empty_i, common_entry_i, ready_i,
        input  uop_pop_o, common_pop_o, valid_o, itype_o, iaddr_o, iretire_o, ilastsize_o,
               cause_o, tval_o, priv_o, err_o, pkt_cnt_o
    );
endinterface

// File: rtl/mure_uop_sequencer.sv
// Merges the uop FIFO and the common FIFO into one trace packet per uop; privilege-changing
// uops pick up a common entry, waiting at most TIMEOUT cycles before emitting without it.
module mure_uop_sequencer #(
    parameter int TIMEOUT       = 16,
    parameter int XLEN          = 32,
    parameter int CAUSE_LEN     = 5,
    parameter int PRIV_LEN      = 2,
    parameter int ITYPE_LEN     = 3,
    parameter int IRETIRE_LEN   = 3,
    parameter int ILASTSIZE_LEN = 1,
    localparam int CNT_W        = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mure_uop_sequencer_if.master bus
);

    localparam logic [ITYPE_LEN-1:0] ITYPE_EXC  = ITYPE_LEN'(1);
    localparam logic [ITYPE_LEN-1:0] ITYPE_INT  = ITYPE_LEN'(2);
    localparam logic [ITYPE_LEN-1:0] ITYPE_ERET = ITYPE_LEN'(3);

    typedef enum logic [1:0] {IDLE, WAIT_C, VALID} state_e;

    state_e                   state;
    state_e                   next_state;
    logic [CNT_W-1:0]         wait_cnt;
    logic                     err_q;
    logic [15:0]              pkt_cnt_q;
    logic [ITYPE_LEN-1:0]     itype_q;
    logic [XLEN-1:0]          iaddr_q;
    logic [IRETIRE_LEN-1:0]   iretire_q;
    logic [ILASTSIZE_LEN-1:0] ilastsize_q;
    logic [CAUSE_LEN-1:0]     cause_q;
    logic [XLEN-1:0]          tval_q;
    logic [PRIV_LEN-1:0]      priv_q;

    logic need_c;
    logic avail;
    logic uop_pop;
    logic common_pop;
    logic load_pkt;
    logic capture_uop;
    logic load_common;
    logic time_out;
    logic xfer;

    assign need_c = (bus.uop_entry_i.itype == ITYPE_EXC) ||
                    (bus.uop_entry_i.itype == ITYPE_INT) ||
                    (bus.uop_entry_i.itype == ITYPE_ERET);
    assign avail  = !bus.uop_empty_i && (!need_c || !bus.common_empty_i);
    assign xfer   = (state == VALID) && bus.ready_i && !bus.flush_i && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // IDLE and a completed transfer in VALID share the same head-of-FIFO decision.
    always_comb begin
        next_state  = state;
        uop_pop     = 1'b0;
        common_pop  = 1'b0;
        load_pkt    = 1'b0;
        capture_uop = 1'b0;
        load_common = 1'b0;
        time_out    = 1'b0;
        if (rst_i || bus.flush_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, VALID: begin
                    if (state == IDLE || bus.ready_i) begin
                        if (avail) begin
                            uop_pop    = 1'b1;
                            common_pop = need_c;
                            load_pkt   = 1'b1;
                            next_state = VALID;
                        end else if (!bus.uop_empty_i) begin
                            uop_pop     = 1'b1;
                            capture_uop = 1'b1;
                            next_state  = WAIT_C;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
                WAIT_C: begin
                    if (!bus.common_empty_i) begin
                        common_pop  = 1'b1;
                        load_common = 1'b1;
                        next_state  = VALID;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        time_out   = 1'b1;
                        next_state = VALID;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.valid_o      = (state == VALID) && !bus.flush_i && !rst_i;
        bus.uop_pop_o    = uop_pop;
        bus.common_pop_o = common_pop;
    end

    // Captured uops clear cause/tval up front so a timeout emits zeros with the old priv.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt    <= '0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
            itype_q     <= '0;
            iaddr_q     <= '0;
            iretire_q   <= '0;
            ilastsize_q <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            priv_q      <= '1;
        end else begin
            if (load_pkt || capture_uop) begin
                itype_q     <= bus.uop_entry_i.itype;
                iaddr_q     <= bus.uop_entry_i.iaddr;
                iretire_q   <= bus.uop_entry_i.iretire;
                ilastsize_q <= bus.uop_entry_i.ilastsize;
            end
            if ((load_pkt && need_c) || load_common) begin
                cause_q <= bus.common_entry_i.cause;
                tval_q  <= bus.common_entry_i.tval;
                priv_q  <= bus.common_entry_i.priv;
            end else if (load_pkt || capture_uop) begin
                cause_q <= '0;
                tval_q  <= '0;
            end
            if (capture_uop) begin
                wait_cnt <= '0;
            end else if (state == WAIT_C && !bus.flush_i && !load_common && !time_out) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (time_out) begin
                err_q <= 1'b1;
            end
            if (xfer) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign bus.itype_o     = itype_q;
    assign bus.iaddr_o     = iaddr_q;
    assign bus.iretire_o   = iretire_q;
    assign bus.ilastsize_o = ilastsize_q;
    assign bus.cause_o     = cause_q;
    assign bus.tval_o      = tval_q;
    assign bus.priv_o      = priv_q;
    assign bus.err_o       = err_q;
    assign bus.pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_mure_uop_sequencer.sv
// Bench for mure_uop_sequencer: FIFO models feed the DUT, a transaction-level model predicts
// each packet when its uop leaves the FIFO, and a monitor compares what the encoder sees.
module tb_mure_uop_sequencer;
    localparam int TIMEOUT = 16;
    localparam logic [2:0] STD  = 3'd0;
    localparam logic [2:0] EXC  = 3'd1;
    localparam logic [2:0] INT  = 3'd2;
    localparam logic [2:0] ERET = 3'd3;
    localparam logic [2:0] TB   = 3'd5;

    typedef struct packed {
        logic [2:0]  itype;
        logic [31:0] iaddr;
        logic [2:0]  iretire;
        logic        ilastsize;
    } uop_t;

    typedef struct packed {
        logic [4:0]  cause;
        logic [31:0] tval;
        logic [1:0]  priv;
    } com_t;

    typedef struct packed {
        uop_t u;
        com_t c;
    } pkt_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    mure_uop_sequencer_if bus ();

    mure_uop_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    uop_t        uq[$];
    com_t        cq[$];
    pkt_t        expq[$];
    bit          ready_val = 1'b0;
    bit          flush_val = 1'b0;
    bit          rst_val   = 1'b1;
    bit          pend_u    = 1'b0;
    bit          pend_c    = 1'b0;
    int          checks    = 0;
    int          errors    = 0;
    bit          wait_act  = 1'b0;
    uop_t        wait_u;
    int          wait_n    = 0;
    logic [1:0]  last_priv = 2'b11;
    bit          err_exp   = 1'b0;
    logic [15:0] pkt_exp   = 16'd0;

    function automatic bit need_c(input logic [2:0] t);
        return (t == EXC) || (t == INT) || (t == ERET);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_i);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] itype, input logic [31:0] iaddr);
        uop_t u;
        u.itype     = itype;
        u.iaddr     = iaddr;
        u.iretire   = 3'($urandom_range(0, 7));
        u.ilastsize = 1'($urandom_range(0, 1));
        uq.push_back(u);
    endtask

    task automatic pushCommon(input logic [4:0] cause, input logic [31:0] tval, input logic [1:0] priv);
        com_t c;
        c.cause = cause;
        c.tval  = tval;
        c.priv  = priv;
        cq.push_back(c);
    endtask

    task automatic drain();
        int n = 0;
        ready_val = 1'b1;
        while ((uq.size() > 0 || expq.size() > 0 || wait_act) && n < 300) begin
            step(1);
            n++;
        end
        checkOutput("drain_done", (uq.size() == 0 && expq.size() == 0 && !wait_act), 1);
    endtask

    // FIFO models: apply the pops the DUT requested, then present the new heads.
    initial begin
        bus.flush_i        = 1'b0;
        bus.ready_i        = 1'b0;
        bus.uop_empty_i    = 1'b1;
        bus.uop_entry_i    = '0;
        bus.common_empty_i = 1'b1;
        bus.common_entry_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (pend_u && uq.size() > 0) uq.delete(0);
            if (pend_c && cq.size() > 0) cq.delete(0);
            rst_i              = rst_val;
            bus.ready_i        = ready_val;
            bus.flush_i        = flush_val;
            bus.uop_empty_i    = (uq.size() == 0);
            bus.uop_entry_i    = (uq.size() > 0) ? uq[0] : '0;
            bus.common_empty_i = (cq.size() == 0);
            bus.common_entry_i = (cq.size() > 0) ? cq[0] : '0;
        end
    end

    // Monitor and reference model, sampled mid-cycle.
    initial begin
        uop_t u;
        pkt_t p;
        forever begin
            @(negedge clk_i);
            pend_u = bus.uop_pop_o;
            pend_c = bus.common_pop_o;
            if (rst_i) begin
                checkOutput("rst_pops", {bus.uop_pop_o, bus.common_pop_o}, 0);
                expq.delete();
                wait_act  = 1'b0;
                last_priv = 2'b11;
                err_exp   = 1'b0;
                pkt_exp   = 16'd0;
                pend_u    = 1'b0;
                pend_c    = 1'b0;
            end else begin
                checkOutput("err", bus.err_o, err_exp);
                checkOutput("pkt_cnt", bus.pkt_cnt_o, pkt_exp);
                checkOutput("valid", bus.valid_o, (expq.size() > 0 && !bus.flush_i));
                if (bus.valid_o && expq.size() > 0)
                    checkOutput("packet", {bus.itype_o, bus.iaddr_o, bus.iretire_o, bus.ilastsize_o,
                                           bus.cause_o, bus.tval_o, bus.priv_o}, expq[0]);
                if (bus.uop_pop_o) checkOutput("upop_nonempty", bus.uop_empty_i, 0);
                if (bus.common_pop_o) checkOutput("cpop_nonempty", bus.common_empty_i, 0);
                if (bus.flush_i) begin
                    checkOutput("flush_pops", {bus.uop_pop_o, bus.common_pop_o}, 0);
                    expq.delete();
                    wait_act = 1'b0;
                    pend_u   = 1'b0;
                    pend_c   = 1'b0;
                end else begin
                    if (bus.valid_o && bus.ready_i && expq.size() > 0) begin
                        expq.delete(0);
                        pkt_exp++;
                    end
                    if (wait_act) begin
                        checkOutput("wait_no_upop", bus.uop_pop_o, 0);
                        if (bus.common_pop_o && cq.size() > 0) begin
                            p.u = wait_u;
                            p.c = cq[0];
                            last_priv = cq[0].priv;
                            expq.push_back(p);
                            wait_act = 1'b0;
                        end else begin
                            checkOutput("wait_common_empty", bus.common_empty_i, 1);
                            wait_n++;
                            if (wait_n == TIMEOUT) begin
                                p.u = wait_u;
                                p.c = '{cause: 5'd0, tval: 32'd0, priv: last_priv};
                                expq.push_back(p);
                                err_exp  = 1'b1;
                                wait_act = 1'b0;
                            end
                        end
                    end else if (bus.uop_pop_o && uq.size() > 0) begin
                        u = uq[0];
                        if (need_c(u.itype) && cq.size() > 0) begin
                            checkOutput("dual_pop", bus.common_pop_o, 1);
                            p.u = u;
                            p.c = cq[0];
                            last_priv = cq[0].priv;
                            expq.push_back(p);
                        end else if (need_c(u.itype)) begin
                            checkOutput("early_cpop", bus.common_pop_o, 0);
                            wait_act = 1'b1;
                            wait_u   = u;
                            wait_n   = 0;
                        end else begin
                            checkOutput("plain_cpop", bus.common_pop_o, 0);
                            p.u = u;
                            p.c = '{cause: 5'd0, tval: 32'd0, priv: last_priv};
                            expq.push_back(p);
                        end
                    end else begin
                        checkOutput("stray_cpop", bus.common_pop_o, 0);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] base;
        int          vcount;

        rst_val = 1'b1;
        step(3);
        rst_val = 1'b0;
        step(2);
        checkOutput("rst_valid", bus.valid_o, 0);
        checkOutput("rst_priv", bus.priv_o, 2'b11);
        checkOutput("rst_cause", bus.cause_o, 0);
        checkOutput("rst_itype", bus.itype_o, 0);
        checkOutput("rst_err", bus.err_o, 0);
        checkOutput("rst_pkt", bus.pkt_cnt_o, 0);

        applyStimulus(TB, 32'h8000_0010);
        step(3);
        checkOutput("t1_valid", bus.valid_o, 1);
        checkOutput("t1_itype", bus.itype_o, TB);
        checkOutput("t1_iaddr", bus.iaddr_o, 32'h8000_0010);
        checkOutput("t1_cause", bus.cause_o, 0);
        checkOutput("t1_priv", bus.priv_o, 2'b11);
        drain();

        ready_val = 1'b0;
        pushCommon(5'd2, 32'h0000_DEAD, 2'b00);
        applyStimulus(EXC, 32'h8000_0100);
        applyStimulus(STD, 32'h8000_0104);
        step(3);
        checkOutput("t2_valid", bus.valid_o, 1);
        checkOutput("t2_cause", bus.cause_o, 2);
        checkOutput("t2_tval", bus.tval_o, 32'h0000_DEAD);
        checkOutput("t2_priv", bus.priv_o, 0);
        drain();
        checkOutput("t2_std_priv", bus.priv_o, 0);
        checkOutput("t2_std_cause", bus.cause_o, 0);

        applyStimulus(INT, 32'h8000_0200);
        step(6);
        pushCommon(5'd7, 32'h0000_1234, 2'b01);
        drain();
        checkOutput("t3_err", bus.err_o, 0);
        checkOutput("t3_priv", bus.priv_o, 2'b01);
        checkOutput("t3_cause", bus.cause_o, 7);

        ready_val = 1'b0;
        applyStimulus(ERET, 32'h8000_0300);
        step(17);
        checkOutput("t4_not_yet", bus.valid_o, 0);
        checkOutput("t4_err_early", bus.err_o, 0);
        step(1);
        checkOutput("t4_valid", bus.valid_o, 1);
        checkOutput("t4_err", bus.err_o, 1);
        checkOutput("t4_cause", bus.cause_o, 0);
        checkOutput("t4_tval", bus.tval_o, 0);
        checkOutput("t4_priv", bus.priv_o, 2'b01);
        drain();

        ready_val = 1'b0;
        applyStimulus(ERET, 32'h8000_0400);
        step(16);
        pushCommon(5'd3, 32'h0000_0BEE, 2'b00);
        step(2);
        checkOutput("t4b_valid", bus.valid_o, 1);
        checkOutput("t4b_cause", bus.cause_o, 3);
        checkOutput("t4b_err_sticky", bus.err_o, 1);
        drain();

        base = pkt_exp;
        ready_val = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(STD, 32'h8000_1000 + 32'(i * 4));
        vcount = 0;
        for (int i = 0; i < 14; i++) begin
            step(1);
            if (bus.valid_o) vcount++;
        end
        checkOutput("t5_valid_cycles", vcount, 10);
        checkOutput("t5_pkt_cnt", bus.pkt_cnt_o, base + 16'd10);
        for (int i = 0; i < 4; i++) applyStimulus(STD, 32'h8000_2000 + 32'(i * 4));
        for (int i = 0; i < 12; i++) begin
            ready_val = i[0];
            step(1);
        end
        drain();

        ready_val = 1'b0;
        applyStimulus(STD, 32'h8000_3000);
        step(3);
        checkOutput("t6_valid_before", bus.valid_o, 1);
        base = pkt_exp;
        ready_val = 1'b1;
        flush_val = 1'b1;
        step(1);
        checkOutput("t6_flush_valid", bus.valid_o, 0);
        flush_val = 1'b0;
        step(1);
        checkOutput("t6_idle_valid", bus.valid_o, 0);
        checkOutput("t6_pkt_kept", bus.pkt_cnt_o, base);
        checkOutput("t6_err_kept", bus.err_o, 1);

        applyStimulus(ERET, 32'h8000_4000);
        step(5);
        rst_val = 1'b1;
        step(2);
        rst_val = 1'b0;
        step(2);
        checkOutput("t6_rst_valid", bus.valid_o, 0);
        checkOutput("t6_rst_err", bus.err_o, 0);
        checkOutput("t6_rst_pkt", bus.pkt_cnt_o, 0);
        checkOutput("t6_rst_priv", bus.priv_o, 2'b11);
        checkOutput("t6_rst_itype", bus.itype_o, 0);

        for (int i = 0; i < 500; i++) begin
            ready_val = ($urandom_range(0, 3) != 0);
            flush_val = ($urandom_range(0, 49) == 0);
            if (uq.size() < 6 && $urandom_range(0, 2) != 0)
                applyStimulus(3'($urandom_range(0, 7)), $urandom);
            if (cq.size() < 4 && $urandom_range(0, 4) == 0)
                pushCommon(5'($urandom_range(0, 31)), $urandom, 2'($urandom_range(0, 3)));
            step(1);
        end
        flush_val = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
